// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a single-write / single-read
// register file. Writes and reads are arbitrated independently, each with its
// own last-granted pointer. Accepted writes reach the register file one cycle
// later; read responses are registered and forward an in-flight write.
module regfile_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_wvalid,
    input  logic [ADDR_WIDTH-1:0] m0_waddr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_wready,
    input  logic                  m0_rvalid,
    input  logic [ADDR_WIDTH-1:0] m0_raddr,
    output logic                  m0_rready,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_data,

    input  logic                  m1_wvalid,
    input  logic [ADDR_WIDTH-1:0] m1_waddr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_wready,
    input  logic                  m1_rvalid,
    input  logic [ADDR_WIDTH-1:0] m1_raddr,
    output logic                  m1_rready,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_data,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);

    // Requester-indexed views of the port pairs
    logic [1:0]            wvalid;
    logic [1:0]            rvalid;
    logic [ADDR_WIDTH-1:0] waddr_in [2];
    logic [DATA_WIDTH-1:0] wdata_in [2];
    logic [ADDR_WIDTH-1:0] raddr_in [2];

    assign wvalid      = {m1_wvalid, m0_wvalid};
    assign rvalid      = {m1_rvalid, m0_rvalid};
    assign waddr_in[0] = m0_waddr;
    assign waddr_in[1] = m1_waddr;
    assign wdata_in[0] = m0_wdata;
    assign wdata_in[1] = m1_wdata;
    assign raddr_in[0] = m0_raddr;
    assign raddr_in[1] = m1_raddr;

    // State
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q [2];
    logic [DATA_WIDTH-1:0] rsp_data_d [2];

    logic [1:0]            wgnt;
    logic [1:0]            rgnt;

    // Round-robin grant: a lone requester wins; on a tie the requester that
    // was not granted last wins. Nothing is granted while reset is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arb
            localparam logic IDX = gi[0];
            assign wgnt[gi] = ~rst & wvalid[gi] & (~wvalid[1-gi] | (wptr_q != IDX));
            assign rgnt[gi] = ~rst & rvalid[gi] & (~rvalid[1-gi] | (rptr_q != IDX));
        end
    endgenerate

    assign m0_wready = wgnt[0];
    assign m1_wready = wgnt[1];
    assign m0_rready = rgnt[0];
    assign m1_rready = rgnt[1];

    // Selected request fields of the winner
    logic [ADDR_WIDTH-1:0] wsel_addr;
    logic [DATA_WIDTH-1:0] wsel_data;
    logic [ADDR_WIDTH-1:0] rsel_addr;
    logic [DATA_WIDTH-1:0] rd_value;

    assign wsel_addr = waddr_in[wgnt[1]];
    assign wsel_data = wdata_in[wgnt[1]];
    assign rsel_addr = raddr_in[rgnt[1]];

    // Register-file side. The write stage and the response valids are masked
    // by reset so a request accepted just before reset never takes effect.
    assign rf_wen       = wen_q & ~rst;
    assign rf_waddr     = waddr_q;
    assign rf_wdata     = wdata_q;
    assign rf_raddr     = (|rgnt) ? rsel_addr : raddr_q;
    assign m0_rsp_valid = rsp_valid_q[0] & ~rst;
    assign m1_rsp_valid = rsp_valid_q[1] & ~rst;
    assign m0_rsp_data  = rsp_data_q[0];
    assign m1_rsp_data  = rsp_data_q[1];

    // Read value: address 0 reads as zero; a write committing this cycle to the
    // same address is forwarded. A write only just accepted is not visible yet.
    always_comb begin
        rd_value = rf_rdata;
        if (rsel_addr == '0) begin
            rd_value = '0;
        end else if (rf_wen && (rf_waddr == rsel_addr)) begin
            rd_value = rf_wdata;
        end
    end

    // Next-state: write stage, read response stage and pointer updates
    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        wen_d         = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        raddr_d       = raddr_q;
        rsp_valid_d   = rgnt;
        rsp_data_d[0] = rsp_data_q[0];
        rsp_data_d[1] = rsp_data_q[1];

        if (|wgnt) begin
            wptr_d = wgnt[1];
            // Address 0 is accepted but never written; outputs keep last value
            if (wsel_addr != '0) begin
                wen_d   = 1'b1;
                waddr_d = wsel_addr;
                wdata_d = wsel_data;
            end
        end

        if (|rgnt) begin
            rptr_d  = rgnt[1];
            raddr_d = rsel_addr;
            if (rgnt[0]) rsp_data_d[0] = rd_value;
            if (rgnt[1]) rsp_data_d[1] = rd_value;
        end

        if (rst) begin
            wptr_d        = 1'b1;
            rptr_d        = 1'b1;
            wen_d         = 1'b0;
            waddr_d       = '0;
            wdata_d       = '0;
            raddr_d       = '0;
            rsp_valid_d   = '0;
            rsp_data_d[0] = '0;
            rsp_data_d[1] = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        wptr_q        <= wptr_d;
        rptr_q        <= rptr_d;
        wen_q         <= wen_d;
        waddr_q       <= waddr_d;
        wdata_q       <= wdata_d;
        raddr_q       <= raddr_d;
        rsp_valid_q   <= rsp_valid_d;
        rsp_data_q[0] <= rsp_data_d[0];
        rsp_data_q[1] <= rsp_data_d[1];
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter. Each cycle the bench predicts grants
// from its own round-robin model and pushes the expected next-cycle write
// stage and read responses to queues; they are popped and compared one cycle
// later. rf_rdata is driven directly by the stimulus.
module tb_regfile_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_wvalid, m1_wvalid, m0_rvalid, m1_rvalid;
    logic [AW-1:0] m0_waddr, m1_waddr, m0_raddr, m1_raddr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_wready, m1_wready, m0_rready, m1_rready;
    logic          m0_rsp_valid, m1_rsp_valid;
    logic [DW-1:0] m0_rsp_data, m1_rsp_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr, rf_raddr;
    logic [DW-1:0] rf_wdata, rf_rdata;

    always #5 clk = ~clk;

    regfile_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_wvalid(m0_wvalid), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wready(m0_wready),
        .m0_rvalid(m0_rvalid), .m0_raddr(m0_raddr), .m0_rready(m0_rready),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
        .m1_wvalid(m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wready(m1_wready),
        .m1_rvalid(m1_rvalid), .m1_raddr(m1_raddr), .m1_rready(m1_rready),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } wexp_t;

    typedef struct {
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic [AW-1:0] raddr;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];

    int checks = 0;
    int errors = 0;

    // Model state: last-granted pointers and the stage contents in effect now
    logic  m_wptr = 1'b1;
    logic  m_rptr = 1'b1;
    wexp_t cur_w  = '{wen: 1'b0, waddr: '0, wdata: '0};
    rexp_t cur_r  = '{v0: 1'b0, d0: '0, v1: 1'b0, d1: '0, raddr: '0};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare this cycle's outputs, predict next
    task automatic step(input string name, input logic r,
                        input logic w0v, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                        input logic w1v, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                        input logic r0v, input logic [AW-1:0] r0a,
                        input logic r1v, input logic [AW-1:0] r1a,
                        input logic [DW-1:0] rdata);
        logic          g_w0, g_w1, g_r0, g_r1;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, rv;
        wexp_t         nw;
        rexp_t         nr;
        rst = r;
        m0_wvalid = w0v; m0_waddr = w0a; m0_wdata = w0d;
        m1_wvalid = w1v; m1_waddr = w1a; m1_wdata = w1d;
        m0_rvalid = r0v; m0_raddr = r0a;
        m1_rvalid = r1v; m1_raddr = r1a;
        rf_rdata  = rdata;
        #1;

        // Stage outputs predicted last cycle
        if (wq.size() > 0 && rq.size() > 0) begin
            cur_w = wq.pop_front();
            cur_r = rq.pop_front();
            if (r) begin
                cur_w.wen = 1'b0;
                cur_r.v0  = 1'b0;
                cur_r.v1  = 1'b0;
            end
            check({name, ".rf_wen"},   DW'(rf_wen),       DW'(cur_w.wen));
            check({name, ".rf_waddr"}, DW'(rf_waddr),     DW'(cur_w.waddr));
            check({name, ".rf_wdata"}, rf_wdata,          cur_w.wdata);
            check({name, ".rsp_v0"},   DW'(m0_rsp_valid), DW'(cur_r.v0));
            check({name, ".rsp_d0"},   m0_rsp_data,       cur_r.d0);
            check({name, ".rsp_v1"},   DW'(m1_rsp_valid), DW'(cur_r.v1));
            check({name, ".rsp_d1"},   m1_rsp_data,       cur_r.d1);
        end

        // Round-robin prediction
        g_w0 = !r && w0v && (!w1v || m_wptr == 1'b1);
        g_w1 = !r && w1v && (!w0v || m_wptr == 1'b0);
        g_r0 = !r && r0v && (!r1v || m_rptr == 1'b1);
        g_r1 = !r && r1v && (!r0v || m_rptr == 1'b0);
        check({name, ".m0_wready"}, DW'(m0_wready), DW'(g_w0));
        check({name, ".m1_wready"}, DW'(m1_wready), DW'(g_w1));
        check({name, ".m0_rready"}, DW'(m0_rready), DW'(g_r0));
        check({name, ".m1_rready"}, DW'(m1_rready), DW'(g_r1));

        wa = g_w1 ? w1a : w0a;
        wd = g_w1 ? w1d : w0d;
        ra = g_r1 ? r1a : r0a;
        if (ra == '0)                                rv = '0;
        else if (cur_w.wen && cur_w.waddr == ra)     rv = cur_w.wdata;
        else                                         rv = rdata;

        if (r) begin
            // Register-file address outputs are only meaningful once reset has
            // been applied at least once; the queue is empty before that.
            if (wq.size() == 0 && checks > 4)
                check({name, ".rf_raddr"}, DW'(rf_raddr), DW'(cur_r.raddr));
        end else begin
            check({name, ".rf_raddr"}, DW'(rf_raddr), DW'((g_r0 || g_r1) ? ra : cur_r.raddr));
        end

        nw = cur_w;
        nw.wen = 1'b0;
        if (g_w0 || g_w1) begin
            m_wptr = g_w1;
            if (wa != '0) begin
                nw.wen = 1'b1; nw.waddr = wa; nw.wdata = wd;
            end
        end
        nr = cur_r;
        nr.v0 = g_r0;
        nr.v1 = g_r1;
        if (g_r0 || g_r1) begin
            m_rptr   = g_r1;
            nr.raddr = ra;
            if (g_r0) nr.d0 = rv;
            if (g_r1) nr.d1 = rv;
        end
        if (r) begin
            m_wptr = 1'b1;
            m_rptr = 1'b1;
            nw = '{wen: 1'b0, waddr: '0, wdata: '0};
            nr = '{v0: 1'b0, d0: '0, v1: 1'b0, d1: '0, raddr: '0};
        end
        wq.push_back(nw);
        rq.push_back(nr);
        $display("%0t %s rst=%0b wgnt=%0b%0b rgnt=%0b%0b rf_wen=%0b rf_waddr=%0d rsp0=%0b/%h rsp1=%0b/%h",
                 $time, name, r, g_w1, g_w0, g_r1, g_r0, rf_wen, rf_waddr,
                 m0_rsp_valid, m0_rsp_data, m1_rsp_valid, m1_rsp_data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name);
        step(name, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 32'h0);
    endtask

    initial begin
        logic [AW-1:0] a0, a1;
        @(posedge clk);
        #1;
        // Reset
        step("reset0", 1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd1, 1'b1, 5'd2, 32'h0);
        step("reset1", 1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd1, 1'b1, 5'd2, 32'h0);

        // Continuous write tie: grants alternate m0, m1, m0 ...
        for (int i = 0; i < 5; i++)
            step("wtie", 1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, '0, 1'b0, '0, 32'h0);
        idle("idle0");

        // Write to address 0 is accepted but never reaches the register file
        step("w_addr0", 1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 32'h0);
        idle("idle1");

        // Bypass: write committing this cycle is forwarded to the read
        step("byp_w", 1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 32'h55, 1'b0, '0, 1'b0, '0, 32'h0);
        step("byp_r", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5, 1'b0, '0, 32'h0);
        idle("idle2");

        // Same-cycle write and read of one address returns the old value
        step("same_wr", 1'b0, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd6, 32'h11);
        idle("idle3");

        // Read of address 0 returns zero
        step("r_addr0", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd0, 32'hDEAD);
        idle("idle4");

        // Read tie plus crossed write/read grants, sustained without bubbles
        for (int i = 0; i < 12; i++) begin
            a0 = AW'($urandom_range(0, 31));
            a1 = AW'($urandom_range(0, 31));
            step("mix", 1'b0, 1'b1, a0, $urandom, (i % 3) != 0, a1, $urandom,
                 1'b1, a1, 1'b1, a0, $urandom);
        end
        step("cross", 1'b0, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd8, 32'h88);
        idle("idle5");

        // Write accepted just before reset is dropped; m0 wins first tie after
        step("pre_rst", 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0, 32'h0);
        step("in_rst", 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 32'h0);
        step("post_tie", 1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b1, 5'd1, 1'b1, 5'd2, 32'h5);
        idle("drain0");
        idle("drain1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have, for each requester n in {0,1}, port mN_wvalid  input  1  write request valid.
REQ-006 SHALL have mN_waddr  input  ADDR_WIDTH  and  mN_wdata  input  DATA_WIDTH  write address and data.
REQ-007 SHALL have mN_wready  output  1  write accepted this cycle.
REQ-008 SHALL have mN_rvalid  input  1,  mN_raddr  input  ADDR_WIDTH,  mN_rready  output  1  read request, address, and acceptance.
REQ-009 SHALL have mN_rsp_valid  output  1  and  mN_rsp_data  output  DATA_WIDTH  read response.
REQ-010 SHALL have rf_wen  output  1,  rf_waddr  output  ADDR_WIDTH,  rf_wdata  output  DATA_WIDTH  register-file write port.
REQ-011 SHALL have rf_raddr  output  ADDR_WIDTH  and  rf_rdata  input  DATA_WIDTH  register-file read port; rf_rdata is combinational from rf_raddr.

Function
REQ-012 Write arbitration SHALL grant at most one requester per cycle; mN_wready = grant, combinational from valids and write pointer.
REQ-013 Only one write valid: that requester granted. Both valid: requester other than last-granted (wptr) granted.
REQ-014 wptr SHALL update to granted index only on a grant cycle; otherwise it holds.
REQ-015 Accepted write SHALL be registered; rf_wen/rf_waddr/rf_wdata driven in the cycle after acceptance (latency 1), committed by register file at that cycle's end.
REQ-016 rf_wen SHALL be 1 only for a cycle following an accepted write with waddr != 0; writes to address 0 are accepted (wready=1) but never drive rf_wen.
REQ-017 rf_wen SHALL be 0 in every cycle not following an accepted write; rf_waddr/rf_wdata hold last value when rf_wen=0.
REQ-018 Read arbitration SHALL use the same round-robin rule with independent pointer rptr; mN_rready = read grant, combinational.
REQ-019 rf_raddr SHALL equal the granted read address in the grant cycle; when no read granted, it holds previous value.
REQ-020 Read data SHALL be registered: mN_rsp_valid pulses for exactly one cycle, the cycle after that requester's accept; mN_rsp_data holds the value until the next response to N.
REQ-021 Read of address 0 SHALL return 0 regardless of rf_rdata.
REQ-022 Bypass: if a read is granted in a cycle where rf_wen=1 and rf_waddr equals the read address (nonzero), response data SHALL be rf_wdata, not rf_rdata.
REQ-023 A write accepted in the same cycle as a read to the same address SHALL NOT be forwarded; that read returns the pre-write value.
REQ-024 Write and read arbitration SHALL be independent; one requester may be granted a write and the other a read in the same cycle.
REQ-025 Back-to-back grants SHALL be sustained: one write and one read accepted per cycle indefinitely, no bubble.

Reset
REQ-026 With rst high at a posedge, next cycle: rf_wen=0, m0_rsp_valid=m1_rsp_valid=0, rsp_data=0, rf_waddr=0, rf_wdata=0, rf_raddr=0, wptr=rptr=1 (m0 wins first tie).
REQ-027 While rst is high, mN_wready and mN_rready SHALL be 0; nothing accepted.
REQ-028 A write or read accepted in the cycle before rst SHALL be dropped: no rf_wen and no rsp_valid after reset.

Verification
REQ-029 Both write-valid every cycle, m0 addr 3 data 0xA, m1 addr 4 data 0xB, post-reset -> grants alternate m0,m1,m0...; rf_wen each cycle from cycle 2, addresses 3,4,3.
REQ-030 m0 writes addr 0 data 0xFFFF -> m0_wready=1, rf_wen stays 0 next cycle.
REQ-031 m1 writes addr 5 data 0x55 in cycle t; m0 reads addr 5 in cycle t+1 with rf_rdata=0x0 -> m0_rsp_valid at t+2, data 0x55 (bypass).
REQ-032 Same-cycle m0 write addr 6 data 0x66 and m1 read addr 6, rf_rdata=0x11 -> m1_rsp_data 0x11 next cycle.
REQ-033 m1 read addr 0 with rf_rdata=0xDEAD -> m1_rsp_data 0.
REQ-034 m0 write accepted at t, rst high at t+1 -> rf_wen 0 at t+1 and t+2; first tie after reset granted to m0.
